centroid_div_sched: RTL and testbench
=====================================

CENTROID_DIV_SCHED -- requirements
Module: centroid_div_sched

Interface
REQ-001 Parameter INPUT_WIDTH, default 11, width of the position outputs.
REQ-002 Parameter SUM_WIDTH, default 27, width of the coordinate sums; also the number of divider iterations per quotient.
REQ-003 Parameter COUNT_WIDTH, default 19, width of the pixel count.
REQ-004 Parameter COUNT_THRESH, default 40, minimum count that counts as an object; legal values are 1 or greater.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 aresetn  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  high = run; low = synchronous abort and clear.
REQ-008 frame_done  input  1  single-cycle end-of-frame pulse; sums and count are valid in the same cycle.
REQ-009 x_sum  input  SUM_WIDTH  accumulated x coordinates of flagged pixels.
REQ-010 y_sum  input  SUM_WIDTH  accumulated y coordinates of flagged pixels.
REQ-011 total_count  input  COUNT_WIDTH  number of flagged pixels.
REQ-012 x_position  output  INPUT_WIDTH  registered centroid x.
REQ-013 y_position  output  INPUT_WIDTH  registered centroid y.
REQ-014 pos_valid  output  1  one-cycle pulse when x_position and y_position update.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 overrun  output  1  sticky flag; set when a frame_done is dropped.

Function
REQ-017 The FSM SHALL have the states IDLE, CHECK, DIV_X, DIV_Y and DONE; one restoring serial divider is shared by the x and y quotients.
REQ-018 In IDLE, with enable=1 and frame_done=1 at cycle T, the block SHALL capture x_sum, y_sum and total_count and enter CHECK at T+1.
REQ-019 In CHECK, if the captured count < COUNT_THRESH, the block SHALL go to DONE at T+2 with result x = y = all ones (2^INPUT_WIDTH-1).
REQ-020 In CHECK otherwise, the block SHALL go to DIV_X for cycles T+2..T+28, one quotient bit per cycle, MSB first, for SUM_WIDTH cycles.
REQ-021 After DIV_X, the block SHALL run DIV_Y for cycles T+29..T+55 and then enter DONE at T+56.
REQ-022 Each quotient SHALL be floor(sum/count), computed at full SUM_WIDTH precision.
REQ-023 A quotient greater than 2^INPUT_WIDTH-2 SHALL saturate to 2^INPUT_WIDTH-2, so that all ones stays reserved for "no object".
REQ-024 In DONE, x_position and y_position SHALL update with pos_valid=1 for exactly that cycle; the next state is IDLE.
REQ-025 x_position and y_position SHALL hold their value between DONE cycles.
REQ-026 A frame_done arriving in any state other than IDLE SHALL be ignored and SHALL set overrun; the result already in progress SHALL not be affected.
REQ-027 A frame_done arriving in IDLE in the cycle right after DONE SHALL be accepted normally.
REQ-028 overrun SHALL stay set until enable=0 or reset.
REQ-029 When enable=0 in any state, the next edge SHALL force:
- state to IDLE;
- x_position and y_position to 0;
- pos_valid, busy and overrun to 0.
REQ-030 When enable=0, frame_done SHALL be ignored and SHALL not set overrun.

Reset
REQ-031 While aresetn=0, the block SHALL be in IDLE with x_position=0, y_position=0, pos_valid=0, busy=0, overrun=0 and all capture and divider registers at 0.
REQ-032 When reset is asserted mid-operation, the computation SHALL be discarded, with no pos_valid after release.
REQ-033 After reset release, the first frame_done SHALL be accepted normally.

Verification
REQ-034 Normal frame: x_sum=64000, y_sum=48000, total_count=200, frame_done at T -> pos_valid at T+56 with x=320, y=240; busy high from T+1 to T+56.
REQ-035 Threshold edges:
- count=39 -> pos_valid at T+2 with x=y=2047;
- count=40, x_sum=400, y_sum=800 -> pos_valid at T+56 with x=10, y=20.
REQ-036 Saturation: x_sum=100000000, count=40 -> x=2046.
REQ-037 Overrun: second frame_done at T+10 -> overrun=1 from T+11, exactly one pos_valid (T+56) carrying the first frame's values; a frame_done at T+57 is accepted.
REQ-038 Abort: enable=0 at T+40 (during DIV_Y) -> at T+41 state IDLE, outputs=0, busy=0, no pos_valid. Reset at T+20 -> same outputs, and a fresh frame after release completes in 56 cycles.

Source files
------------

// File: rtl/centroid_div_sched_if.sv
// Frame-statistics in, centroid result out; the block owns the slave side.
interface centroid_div_sched_if #(
    parameter int INPUT_WIDTH = 11,
    parameter int SUM_WIDTH   = 27,
    parameter int COUNT_WIDTH = 19
);
    logic                   enable;
    logic                   frame_done;
    logic [SUM_WIDTH-1:0]   x_sum;
    logic [SUM_WIDTH-1:0]   y_sum;
    logic [COUNT_WIDTH-1:0] total_count;
    logic [INPUT_WIDTH-1:0] x_position;
    logic [INPUT_WIDTH-1:0] y_position;
    logic                   pos_valid;
    logic                   busy;
    logic                   overrun;

    modport master (
        output enable, frame_done, x_sum, y_sum, total_count,
        input  x_position, y_position, pos_valid, busy, overrun
    );

    modport slave (
        input  enable, frame_done, x_sum, y_sum, total_count,
        output x_position, y_position, pos_valid, busy, overrun
    );
endinterface

// File: rtl/centroid_div_sched.sv
// Centroid = sum/count via one shared restoring divider, x then y.
// Latency 56 cycles for an object, 2 cycles under threshold; no backpressure, frames arriving while busy are dropped and flagged.
// Outputs are registered and hold between result pulses.
module centroid_div_sched #(
    parameter int INPUT_WIDTH  = 11,
    parameter int SUM_WIDTH    = 27,
    parameter int COUNT_WIDTH  = 19,
    parameter int COUNT_THRESH = 40
) (
    input  logic                 clk,
    input  logic                 aresetn,
    centroid_div_sched_if.slave  bus
);
    localparam int IW  = INPUT_WIDTH;
    localparam int SW  = SUM_WIDTH;
    localparam int CW  = COUNT_WIDTH;
    localparam int ITW = (SW > 1) ? $clog2(SW) : 1;

    localparam logic [IW-1:0] NO_OBJ  = {IW{1'b1}};
    localparam logic [IW-1:0] SAT_IW  = {{(IW-1){1'b1}}, 1'b0};
    localparam logic [SW-1:0] SAT_SW  = {{(SW-IW){1'b0}}, SAT_IW};
    localparam logic [CW-1:0] THRESH  = CW'(COUNT_THRESH);
    localparam logic [ITW-1:0] LAST_IT = ITW'(SW - 1);

    typedef enum logic [2:0] {IDLE, CHECK, DIV_X, DIV_Y, DONE} state_t;

    state_t          state_q;
    logic [SW-1:0]   dq_q;      // dividend shifts out the top, quotient shifts in the bottom
    logic [SW-1:0]   ysum_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   rem_q;
    logic [ITW-1:0]  iter_q;
    logic [IW-1:0]   xres_q;
    logic [IW-1:0]   xpos_q;
    logic [IW-1:0]   ypos_q;
    logic            pv_q;
    logic            busy_q;
    logic            ovr_q;

    logic [CW:0]     trial_d;
    logic            ge_d;
    logic [CW-1:0]   rem_d;
    logic [SW-1:0]   dq_d;
    logic [IW-1:0]   sat_d;
    logic            last_d;

    // When the trial fits, the true difference is below cnt_q, so CW-bit modular subtraction is exact.
    assign trial_d = {rem_q, dq_q[SW-1]};
    assign ge_d    = (trial_d >= {1'b0, cnt_q});
    assign rem_d   = ge_d ? (trial_d[CW-1:0] - cnt_q) : trial_d[CW-1:0];
    assign dq_d    = {dq_q[SW-2:0], ge_d};
    assign sat_d   = (dq_d > SAT_SW) ? SAT_IW : dq_d[IW-1:0];
    assign last_d  = (iter_q == LAST_IT);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            dq_q    <= '0;
            ysum_q  <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            iter_q  <= '0;
            xres_q  <= '0;
            xpos_q  <= '0;
            ypos_q  <= '0;
            pv_q    <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (!bus.enable) begin
            state_q <= IDLE;
            dq_q    <= '0;
            ysum_q  <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            iter_q  <= '0;
            xres_q  <= '0;
            xpos_q  <= '0;
            ypos_q  <= '0;
            pv_q    <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            pv_q <= 1'b0;
            if (bus.frame_done && (state_q != IDLE))
                ovr_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (bus.frame_done) begin
                        dq_q    <= bus.x_sum;
                        ysum_q  <= bus.y_sum;
                        cnt_q   <= bus.total_count;
                        rem_q   <= '0;
                        iter_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (cnt_q < THRESH) begin
                        xpos_q  <= NO_OBJ;
                        ypos_q  <= NO_OBJ;
                        pv_q    <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= DIV_X;
                    end
                end
                DIV_X: begin
                    dq_q   <= dq_d;
                    rem_q  <= rem_d;
                    iter_q <= iter_q + 1'b1;
                    if (last_d) begin
                        xres_q  <= sat_d;
                        dq_q    <= ysum_q;
                        rem_q   <= '0;
                        iter_q  <= '0;
                        state_q <= DIV_Y;
                    end
                end
                DIV_Y: begin
                    dq_q   <= dq_d;
                    rem_q  <= rem_d;
                    iter_q <= iter_q + 1'b1;
                    if (last_d) begin
                        xpos_q  <= xres_q;
                        ypos_q  <= sat_d;
                        pv_q    <= 1'b1;
                        iter_q  <= '0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.x_position = xpos_q;
    assign bus.y_position = ypos_q;
    assign bus.pos_valid  = pv_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_centroid_div_sched.sv
// Directed bench: hand-computed centroids, threshold and saturation edges, overrun, abort and reset.
module tb_centroid_div_sched;
    logic clk = 1'b0;
    logic aresetn = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    centroid_div_sched_if bus ();

    centroid_div_sched dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; frame_done is raised in the current cycle T.
    task automatic run_frame(input string tag, input logic [26:0] xs, input logic [26:0] ys,
                             input logic [18:0] c, input int lat, input int ex, input int ey,
                             input int inj, input int exp_ovr);
        int pvc = 0;
        int pva = -1;
        int busy_low = 0;
        logic [10:0] px = '0;
        logic [10:0] py = '0;
        bus.x_sum = xs;
        bus.y_sum = ys;
        bus.total_count = c;
        bus.frame_done = 1'b1;
        for (int n = 1; n <= lat + 1; n++) begin
            @(negedge clk);
            if (bus.pos_valid) begin
                pvc++;
                pva = n;
                px = bus.x_position;
                py = bus.y_position;
            end
            if (n <= lat && !bus.busy) busy_low++;
            if (inj > 0 && n == inj + 1) chk({tag, "_ovr_set"}, 32'(bus.overrun), 1);
            if (n == 1) bus.frame_done = 1'b0;
            if (inj > 0 && n == inj) begin
                bus.frame_done = 1'b1;
                bus.x_sum = 27'd999;
                bus.y_sum = 27'd777;
                bus.total_count = 19'd1;
            end
            if (inj > 0 && n == inj + 1) bus.frame_done = 1'b0;
        end
        chk({tag, "_pv_count"}, 32'(pvc), 1);
        chk({tag, "_pv_cycle"}, 32'(pva), 32'(lat));
        chk({tag, "_x"}, 32'(px), 32'(ex));
        chk({tag, "_y"}, 32'(py), 32'(ey));
        chk({tag, "_busy_gaps"}, 32'(busy_low), 0);
        chk({tag, "_busy_after"}, 32'(bus.busy), 0);
        chk({tag, "_x_hold"}, 32'(bus.x_position), 32'(ex));
        chk({tag, "_ovr_end"}, 32'(bus.overrun), 32'(exp_ovr));
    endtask

    // mode 0: enable dropped at T+40; mode 1: reset asserted at T+20.
    task automatic abort_run(input string tag, input int mode);
        int pvc = 0;
        int at = (mode == 0) ? 40 : 20;
        bus.x_sum = 27'd64000;
        bus.y_sum = 27'd48000;
        bus.total_count = 19'd200;
        bus.frame_done = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (bus.pos_valid) pvc++;
            if (n == at + 1) begin
                chk({tag, "_busy"}, 32'(bus.busy), 0);
                chk({tag, "_x"}, 32'(bus.x_position), 0);
                chk({tag, "_y"}, 32'(bus.y_position), 0);
                chk({tag, "_pv"}, 32'(bus.pos_valid), 0);
                chk({tag, "_ovr"}, 32'(bus.overrun), 0);
            end
            if (n == 1) bus.frame_done = 1'b0;
            if (n == 5) bus.frame_done = 1'b1;
            if (n == 6) bus.frame_done = 1'b0;
            if (mode == 0 && n == at) bus.enable = 1'b0;
            if (mode == 0 && n == at + 1) bus.enable = 1'b1;
            if (mode == 1 && n == at) aresetn = 1'b0;
            if (mode == 1 && n == at + 1) aresetn = 1'b1;
        end
        chk({tag, "_no_pv"}, 32'(pvc), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable = 1'b0;
        bus.frame_done = 1'b0;
        bus.x_sum = '0;
        bus.y_sum = '0;
        bus.total_count = '0;
        repeat (3) @(negedge clk);
        chk("rst_x", 32'(bus.x_position), 0);
        chk("rst_y", 32'(bus.y_position), 0);
        chk("rst_pv", 32'(bus.pos_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ovr", 32'(bus.overrun), 0);
        aresetn = 1'b1;
        bus.enable = 1'b1;
        @(negedge clk);

        run_frame("normal", 27'd64000, 27'd48000, 19'd200, 56, 320, 240, 0, 0);
        run_frame("thr39", 27'd1234, 27'd5678, 19'd39, 2, 2047, 2047, 0, 0);
        run_frame("thr40", 27'd400, 27'd800, 19'd40, 56, 10, 20, 0, 0);
        run_frame("cnt0", 27'd0, 27'd0, 19'd0, 2, 2047, 2047, 0, 0);
        run_frame("sat", 27'd100000000, 27'd2000, 19'd40, 56, 2046, 50, 0, 0);
        run_frame("edge2046", 27'd204600, 27'd204700, 19'd100, 56, 2046, 2046, 0, 0);
        run_frame("maxin", 27'd134217727, 27'd5, 19'd524287, 56, 256, 0, 0, 0);
        run_frame("ovr", 27'd64000, 27'd48000, 19'd200, 56, 320, 240, 10, 1);
        run_frame("accept57", 27'd400, 27'd800, 19'd40, 56, 10, 20, 0, 1);

        bus.enable = 1'b0;
        bus.frame_done = 1'b1;
        @(negedge clk);
        chk("dis_ovr", 32'(bus.overrun), 0);
        chk("dis_busy", 32'(bus.busy), 0);
        chk("dis_x", 32'(bus.x_position), 0);
        @(negedge clk);
        chk("dis_fd_ignored", 32'(bus.busy), 0);
        bus.frame_done = 1'b0;
        bus.enable = 1'b1;
        @(negedge clk);

        run_frame("pre_abort", 27'd64000, 27'd48000, 19'd200, 56, 320, 240, 0, 0);
        abort_run("abort_en", 0);
        run_frame("pre_reset", 27'd400, 27'd800, 19'd40, 56, 10, 20, 0, 0);
        abort_run("abort_rst", 1);
        run_frame("post_reset", 27'd64000, 27'd48000, 19'd200, 56, 320, 240, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
